// File: rtl/fsm_input_conditioner_pkg.sv
// fsm_input_conditioner_pkg: channel state encoding and default debounce sizing
package fsm_input_conditioner_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } chan_state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W = 8;
endpackage

// File: rtl/fsm_input_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchroniser plus debounce FSM giving a clean level and rise strobe
module debounce_channel
  import fsm_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic r_q1, r_q2, r_level, r_rise, w_level_nxt, w_rise_nxt;
  chan_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  // synchroniser, state, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_q1    <= i_raw;
      r_q2    <= r_q1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
    end
  end
  // a new level is accepted only after DEBOUNCE_CYCLES identical samples; any reversal restarts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        w_state_nxt = r_q2 ? PEND_HI : STABLE_LO;
        w_cnt_nxt   = r_q2 ? CNT_W'(1) : '0;
      end
      PEND_HI: begin
        if (!r_q2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        w_state_nxt = r_q2 ? STABLE_HI : PEND_LO;
        w_cnt_nxt   = r_q2 ? '0 : CNT_W'(1);
      end
      PEND_LO: begin
        if (r_q2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end
  assign o_level = r_level;
  assign o_rise  = r_rise;
endmodule

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner: debounced op/select levels and rise strobes for the control FSM
module fsm_input_conditioner
  import fsm_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic op_raw,
  input  logic select_raw,
  output logic op,
  output logic select,
  output logic op_rise,
  output logic select_rise
);
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_op (
    .clk(clk), .rst_n(rst_n), .i_raw(op_raw), .o_level(op), .o_rise(op_rise)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_select (
    .clk(clk), .rst_n(rst_n), .i_raw(select_raw), .o_level(select), .o_rise(select_rise)
  );
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner: vector table, corner sequences and random stimulus against a history model
module tb_fsm_input_conditioner;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, op_raw = 1'b0, select_raw = 1'b0;
  logic op, select, op_rise, select_rise;
  int checks = 0, failures = 0;
  typedef struct {logic o, s, eo, es, ero, ers;} vec_t;
  vec_t tv[$];
  logic [1:0] w_raw, m_p1 = '0, m_p2 = '0, m_lvl = '0, m_rise = '0;
  logic [D-1:0] m_hist [2] = '{default: '0};
  int hold_o = 0, hold_s = 0, pulses;
  logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_raw(op_raw), .select_raw(select_raw),
    .op(op), .select(select), .op_rise(op_rise), .select_rise(select_rise)
  );

  always #5 clk = ~clk;
  assign w_raw = {select_raw, op_raw};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic o, s, eo, es, ero, ers);
    vec_t v;
    v = '{o, s, eo, es, ero, ers};
    tv.push_back(v);
  endfunction

  // reference: level flips once the last D synchronised samples all disagree with it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 <= '0; m_p2 <= '0; m_lvl <= '0; m_rise <= '0;
      m_hist[0] <= '0; m_hist[1] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_hist[c] <= {m_hist[c][D-2:0], m_p2[c]};
        m_p2[c] <= m_p1[c];
        m_p1[c] <= w_raw[c];
        m_rise[c] <= 1'b0;
        if ({m_hist[c][D-2:0], m_p2[c]} == {D{~m_lvl[c]}}) begin
          m_lvl[c] <= ~m_lvl[c];
          m_rise[c] <= ~m_lvl[c];
        end
      end
    end
  end

  // every cycle the DUT must agree with the reference
  always @(negedge clk) begin
    chk("model_level", int'({select, op}), int'(m_lvl));
    chk("model_rise", int'({select_rise, op_rise}), int'(m_rise));
  end

  initial begin
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 1, 0, 0); add(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 0, 0);
    add(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(1, 1, 1, 1, 0, 0);
    repeat (20) begin
      @(negedge clk); #2;
      op_raw = 1'($urandom); select_raw = 1'($urandom);
      #1 chk("reset_hold", int'({op, select, op_rise, select_rise}), 0);
    end
    @(negedge clk); #2;
    op_raw = 1'b0; select_raw = 1'b0; rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      chk("release_no_strobe", int'({op, select, op_rise, select_rise}), 0);
      #2;
    end
    for (int i = 0; i < tv.size(); i++) begin
      op_raw = tv[i].o; select_raw = tv[i].s;
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d_level", i), int'({select, op}), int'({tv[i].es, tv[i].eo}));
      chk($sformatf("vec%0d_rise", i), int'({select_rise, op_rise}), int'({tv[i].ers, tv[i].ero}));
      #2;
    end
    op_raw = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); #2; end
    chk("pre_pend_levels", int'({select, op}), 2);
    op_raw = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 chk("reset_mid_pend", int'({op, select, op_rise, select_rise}), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("post_reset%0d_level", j), int'({select, op}), (j >= 5) ? 3 : 0);
      chk($sformatf("post_reset%0d_rise", j), int'({select_rise, op_rise}), (j == 5) ? 3 : 0);
      #2;
    end
    select_raw = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); #2; end
    pulses = 0;
    for (int k = 0; k < 17; k++) begin
      select_raw = (k < 5) ? pat[k] : 1'b1;
      @(posedge clk); @(negedge clk);
      chk($sformatf("bounce%0d_level", k), int'(select), (k >= 10) ? 1 : 0);
      pulses += int'(select_rise);
      #2;
    end
    chk("bounce_pulses", pulses, 1);
    for (int n = 0; n < 800; n++) begin
      if (hold_o == 0) begin op_raw = 1'($urandom); hold_o = $urandom_range(1, 7); end
      if (hold_s == 0) begin select_raw = 1'($urandom); hold_s = $urandom_range(1, 7); end
      hold_o--; hold_s--;
      if (n == 300 || n == 550) begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #2;
      end else begin
        @(posedge clk); @(negedge clk); #2;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
